// File: rtl/batkiri_pkg.sv
// Shared Batkiri decode definitions: field widths, opcodes, control encodings and the opcode control table.
// The TRAP FSM state only exists when DECODE_ILLEGAL_TRAP_EN is defined.
package batkiri_pkg;

  localparam int IW      = 17;
  localparam int OPW     = 5;
  localparam int RAW     = 3;
  localparam int SHW     = 3;
  localparam int FW      = IW - OPW;
  localparam int NUM_OPS = 21;

  typedef logic [OPW-1:0] opcode_t;

  localparam opcode_t OP_NOP = opcode_t'(0);
  localparam opcode_t OP_JMP = opcode_t'(1);
  localparam opcode_t OP_JPL = opcode_t'(2);
  localparam opcode_t OP_BRZ = opcode_t'(3);
  localparam opcode_t OP_BRN = opcode_t'(4);
  localparam opcode_t OP_LSL = opcode_t'(5);
  localparam opcode_t OP_LSR = opcode_t'(6);
  localparam opcode_t OP_LD  = opcode_t'(7);
  localparam opcode_t OP_ST  = opcode_t'(8);
  localparam opcode_t OP_LDI = opcode_t'(9);
  localparam opcode_t OP_MOV = opcode_t'(10);
  localparam opcode_t OP_INC = opcode_t'(11);
  localparam opcode_t OP_DEC = opcode_t'(12);
  localparam opcode_t OP_NEG = opcode_t'(13);
  localparam opcode_t OP_NOT = opcode_t'(14);
  localparam opcode_t OP_AND = opcode_t'(15);
  localparam opcode_t OP_ADD = opcode_t'(16);
  localparam opcode_t OP_SUB = opcode_t'(17);
  localparam opcode_t OP_OR  = opcode_t'(18);
  localparam opcode_t OP_OUT = opcode_t'(19);
  localparam opcode_t OP_INP = opcode_t'(20);

  localparam logic [3:0] FS_PASSA = 4'b0000;
  localparam logic [3:0] FS_ADD   = 4'b0001;
  localparam logic [3:0] FS_SUB   = 4'b0010;
  localparam logic [3:0] FS_INC   = 4'b0011;
  localparam logic [3:0] FS_DEC   = 4'b0100;
  localparam logic [3:0] FS_NEG   = 4'b0101;
  localparam logic [3:0] FS_SHL   = 4'b0110;
  localparam logic [3:0] FS_SHR   = 4'b0111;
  localparam logic [3:0] FS_PASSB = 4'b1000;
  localparam logic [3:0] FS_AND   = 4'b1001;
  localparam logic [3:0] FS_OR    = 4'b1010;
  localparam logic [3:0] FS_LINK  = 4'b1100;
  localparam logic [3:0] FS_NOT   = 4'b1101;

  localparam logic [1:0] BS_NEXT = 2'b00;
  localparam logic [1:0] BS_JUMP = 2'b01;
  localparam logic [1:0] BS_BRZ  = 2'b10;

  localparam logic [1:0] MD_FU  = 2'b00;
  localparam logic [1:0] MD_MEM = 2'b01;
  localparam logic [1:0] MD_IN  = 2'b10;

  typedef struct packed {
    logic           rw, ps, mw, ma, mb, cs, oe;
    logic [1:0]     md, bs;
    logic [3:0]     fs;
    logic [RAW-1:0] da, aa, ba;
    logic [SHW-1:0] sh;
  } ctrl_t;

  // Static controls plus which instruction fields feed da/aa/ba/sh.
  typedef struct packed {
    logic       rw, ps, mw, ma, mb, cs, oe;
    logic [1:0] md, bs;
    logic [3:0] fs;
    logic       use_da, use_aa, use_ba, use_sh;
  } ctrl_src_t;

  typedef enum logic [1:0] {
    RUN,
    JPL2
`ifdef DECODE_ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  //          rw    ps    mw    ma    mb    cs    oe    md      bs       fs        da    aa    ba    sh
  localparam ctrl_src_t CTRL_TABLE [NUM_OPS] = '{
    /*NOP*/ '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MD_FU,  BS_NEXT, FS_PASSA, 1'b0, 1'b0, 1'b0, 1'b0},
    /*JMP*/ '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, MD_FU,  BS_JUMP, FS_PASSB, 1'b0, 1'b1, 1'b0, 1'b0},
    /*JPL*/ '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MD_FU,  BS_NEXT, FS_LINK,  1'b1, 1'b1, 1'b0, 1'b0},
    /*BRZ*/ '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, MD_FU,  BS_BRZ,  FS_PASSB, 1'b0, 1'b1, 1'b0, 1'b0},
    /*BRN*/ '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, MD_FU,  BS_BRZ,  FS_PASSB, 1'b0, 1'b1, 1'b0, 1'b0},
    /*LSL*/ '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MD_FU,  BS_NEXT, FS_SHL,   1'b1, 1'b1, 1'b0, 1'b1},
    /*LSR*/ '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MD_FU,  BS_NEXT, FS_SHR,   1'b1, 1'b1, 1'b0, 1'b1},
    /*LD */ '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MD_MEM, BS_NEXT, FS_PASSA, 1'b1, 1'b1, 1'b0, 1'b0},
    /*ST */ '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, MD_FU,  BS_NEXT, FS_PASSA, 1'b0, 1'b1, 1'b1, 1'b0},
    /*LDI*/ '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, MD_FU,  BS_NEXT, FS_PASSB, 1'b1, 1'b0, 1'b0, 1'b0},
    /*MOV*/ '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MD_FU,  BS_NEXT, FS_PASSA, 1'b1, 1'b1, 1'b0, 1'b0},
    /*INC*/ '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MD_FU,  BS_NEXT, FS_INC,   1'b1, 1'b1, 1'b0, 1'b0},
    /*DEC*/ '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MD_FU,  BS_NEXT, FS_DEC,   1'b1, 1'b1, 1'b0, 1'b0},
    /*NEG*/ '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MD_FU,  BS_NEXT, FS_NEG,   1'b1, 1'b1, 1'b0, 1'b0},
    /*NOT*/ '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MD_FU,  BS_NEXT, FS_NOT,   1'b1, 1'b1, 1'b0, 1'b0},
    /*AND*/ '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MD_FU,  BS_NEXT, FS_AND,   1'b1, 1'b1, 1'b1, 1'b0},
    /*ADD*/ '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MD_FU,  BS_NEXT, FS_ADD,   1'b1, 1'b1, 1'b1, 1'b0},
    /*SUB*/ '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MD_FU,  BS_NEXT, FS_SUB,   1'b1, 1'b1, 1'b1, 1'b0},
    /*OR */ '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MD_FU,  BS_NEXT, FS_OR,    1'b1, 1'b1, 1'b1, 1'b0},
    /*OUT*/ '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, MD_FU,  BS_NEXT, FS_PASSA, 1'b0, 1'b1, 1'b0, 1'b0},
    /*INP*/ '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MD_IN,  BS_NEXT, FS_PASSA, 1'b1, 1'b0, 1'b0, 1'b0}
  };

  function automatic logic is_legal(input opcode_t op);
    return int'(op) < NUM_OPS;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side instruction handshake and control-word handshake of the Batkiri decode stage.
interface decode_stage_if;
  import batkiri_pkg::*;

  logic           in_valid, in_ready;
  logic [IW-1:0]  instruction;
  logic           flush;
  logic           out_valid, out_ready;
  logic           rw, ps, mw, ma, mb, cs, oe;
  logic [1:0]     md, bs;
  logic [3:0]     fs;
  logic [RAW-1:0] da, aa, ba;
  logic [SHW-1:0] sh;
  logic           uop_last;
  logic           illegal;

  modport slave (
    input  in_valid, instruction, flush, out_ready,
    output in_ready, out_valid, rw, ps, mw, ma, mb, cs, oe,
           md, bs, fs, da, aa, ba, sh, uop_last, illegal
  );

  modport master (
    output in_valid, instruction, flush, out_ready,
    input  in_ready, out_valid, rw, ps, mw, ma, mb, cs, oe,
           md, bs, fs, da, aa, ba, sh, uop_last, illegal
  );
endinterface

// File: rtl/decode_lut.sv
// Combinational opcode + register/shift fields to control word; unknown opcodes decode as NOP.
module decode_lut
  import batkiri_pkg::*;
(
  input  opcode_t       opcode,
  input  logic [FW-1:0] fields,
  output ctrl_t         ctrl
);

  ctrl_src_t src;

  // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
  always_comb begin
    src = CTRL_TABLE[0];
    if (is_legal(opcode)) src = CTRL_TABLE[opcode];

    ctrl    = '0;
    ctrl.rw = src.rw;
    ctrl.ps = src.ps;
    ctrl.mw = src.mw;
    ctrl.ma = src.ma;
    ctrl.mb = src.mb;
    ctrl.cs = src.cs;
    ctrl.oe = src.oe;
    ctrl.md = src.md;
    ctrl.bs = src.bs;
    ctrl.fs = src.fs;
    ctrl.da = src.use_da ? fields[FW-1 -: RAW]         : '0;
    ctrl.aa = src.use_aa ? fields[FW-1-RAW -: RAW]     : '0;
    ctrl.ba = src.use_ba ? fields[FW-1-2*RAW -: RAW]   : '0;
    ctrl.sh = src.use_sh ? fields[SHW-1:0]             : '0;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered valid/ready decode stage with JPL link+jump expansion and flush.
// Define DECODE_ILLEGAL_TRAP_EN to trap on illegal opcodes (sticky flag, TRAP state until flush).
module decode_stage
  import batkiri_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  decode_stage_if.slave  bus
);

  state_t        state, state_next;
  ctrl_t         ctrl_q, lut_ctrl;
  logic          out_valid_q, uop_last_q;
  logic [FW-1:0] jpl_fields, lut_fields;
  opcode_t       opcode_in, lut_opcode;
  logic          in_ready, accept, take, uop2_load, load;

  assign opcode_in = bus.instruction[IW-1 -: OPW];
  assign take      = out_valid_q && bus.out_ready;
  assign accept    = bus.in_valid && in_ready;
  assign load      = (accept || uop2_load) && !bus.flush;

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic op_illegal;
  assign op_illegal = !is_legal(opcode_in);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (accept && opcode_in == OP_JPL) state_next = JPL2;
`ifdef DECODE_ILLEGAL_TRAP_EN
          else if (accept && op_illegal)     state_next = TRAP;
`endif
        end
        JPL2:    if (uop2_load) state_next = RUN;
`ifdef DECODE_ILLEGAL_TRAP_EN
        TRAP:    state_next = TRAP;
`endif
        default: state_next = RUN;
      endcase
    end
  end

  // The second JPL micro-op is the JMP decode of the saved link instruction's fields.
  always_comb begin
    in_ready   = rst_n && (state == RUN) && (!out_valid_q || bus.out_ready);
    uop2_load  = (state == JPL2) && take;
    lut_opcode = opcode_in;
    lut_fields = bus.instruction[FW-1:0];
    if (state == JPL2) begin
      lut_opcode = OP_JMP;
      lut_fields = jpl_fields;
    end
  end

  decode_lut u_lut (
    .opcode (lut_opcode),
    .fields (lut_fields),
    .ctrl   (lut_ctrl)
  );

  // NOTE: jpl_fields is plain data, only read in JPL2 after being written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept && opcode_in == OP_JPL) jpl_fields <= bus.instruction[FW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      uop_last_q  <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      ctrl_q      <= lut_ctrl;
      uop_last_q  <= (state == JPL2) || (opcode_in != OP_JPL);
    end else if (take) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                           illegal_q <= 1'b0;
    else if (bus.flush)                   illegal_q <= 1'b0;
    else if (accept && op_illegal)        illegal_q <= 1'b1;
  end
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.uop_last  = uop_last_q;
  assign bus.rw        = ctrl_q.rw;
  assign bus.ps        = ctrl_q.ps;
  assign bus.mw        = ctrl_q.mw;
  assign bus.ma        = ctrl_q.ma;
  assign bus.mb        = ctrl_q.mb;
  assign bus.cs        = ctrl_q.cs;
  assign bus.oe        = ctrl_q.oe;
  assign bus.md        = ctrl_q.md;
  assign bus.bs        = ctrl_q.bs;
  assign bus.fs        = ctrl_q.fs;
  assign bus.da        = ctrl_q.da;
  assign bus.aa        = ctrl_q.aa;
  assign bus.ba        = ctrl_q.ba;
  assign bus.sh        = ctrl_q.sh;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized run against a micro-op queue model.
module tb_decode_stage;

  typedef struct packed {
    logic       rw, ps, mw, ma, mb, cs, oe;
    logic [1:0] md, bs;
    logic [3:0] fs;
    logic [2:0] da, aa, ba, sh;
    logic       uop_last;
  } word_t;

  localparam logic [16:0] I_ADD = 17'h10688;
  localparam logic [16:0] I_LSL = 17'h05645;
  localparam logic [16:0] I_JPL = 17'h024C0;
  localparam logic [16:0] I_ILL = 17'h1F000;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;
  word_t exp_q[$];

  always #5 clk = ~clk;

  decode_stage_if bus();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic word_t obs();
    word_t w;
    w = {bus.rw, bus.ps, bus.mw, bus.ma, bus.mb, bus.cs, bus.oe, bus.md, bus.bs,
         bus.fs, bus.da, bus.aa, bus.ba, bus.sh, bus.uop_last};
    return w;
  endfunction

  function automatic word_t nop_word();
    word_t w;
    w = '0;
    w.uop_last = 1'b1;
    return w;
  endfunction

  function automatic word_t add_word();
    word_t w;
    w = '0;
    w.rw = 1'b1; w.da = 3'd3; w.aa = 3'd2; w.ba = 3'd1; w.fs = 4'b0001; w.uop_last = 1'b1;
    return w;
  endfunction

  // Reference model: the micro-op words an accepted instruction must produce, in order.
  task automatic push_model(input logic [16:0] ins);
    word_t w1, w2;
    w1 = '0;
    w2 = '0;
    case (ins[16:12])
      5'd16: begin
        w1.rw = 1'b1; w1.da = ins[11:9]; w1.aa = ins[8:6]; w1.ba = ins[5:3];
        w1.fs = 4'b0001; w1.uop_last = 1'b1;
        exp_q.push_back(w1);
      end
      5'd5: begin
        w1.rw = 1'b1; w1.da = ins[11:9]; w1.aa = ins[8:6]; w1.sh = ins[2:0];
        w1.fs = 4'b0110; w1.uop_last = 1'b1;
        exp_q.push_back(w1);
      end
      5'd2: begin
        w1.rw = 1'b1; w1.da = ins[11:9]; w1.aa = ins[8:6]; w1.fs = 4'b1100;
        w2.bs = 2'b01; w2.fs = 4'b1000; w2.mb = 1'b1; w2.cs = 1'b1; w2.aa = ins[8:6];
        w2.uop_last = 1'b1;
        exp_q.push_back(w1);
        exp_q.push_back(w2);
      end
      default: exp_q.push_back(nop_word());
    endcase
  endtask

  // Apply inputs just after a falling edge, then settle so outputs/in_ready can be sampled.
  task automatic drive(input logic v, input logic [16:0] ins, input logic ordy, input logic fl);
    @(negedge clk);
    bus.in_valid    = v;
    bus.instruction = ins;
    bus.out_ready   = ordy;
    bus.flush       = fl;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, I_ADD, 1'b1, 1'b0);
    tests_run++;
    if (bus.in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    drive(1'b1, I_ADD, 1'b1, 1'b0);
    tests_run++;
    if (bus.out_valid !== 1'b0 || obs() !== '0 || bus.illegal !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b word=%h illegal=%b want 0/0/0",
               bus.out_valid, obs(), bus.illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_add();
    drive(1'b1, I_ADD, 1'b1, 1'b0);
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL add_in_ready: got %b want 1", bus.in_ready);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (bus.out_valid !== 1'b1 || obs() !== add_word()) begin
      tests_failed++;
      $display("FAIL add_word: got valid=%b word=%h want 1/%h", bus.out_valid, obs(), add_word());
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL add_drain: got valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_lsl_backpressure();
    word_t e;
    e = '0;
    e.rw = 1'b1; e.da = 3'd3; e.aa = 3'd1; e.fs = 4'b0110; e.sh = 3'd5; e.uop_last = 1'b1;
    drive(1'b1, I_LSL, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, I_ADD, 1'b0, 1'b0);
      tests_run++;
      if (bus.out_valid !== 1'b1 || obs() !== e || bus.in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL lsl_hold[%0d]: got valid=%b word=%h rdy=%b want 1/%h/0",
                 i, bus.out_valid, obs(), bus.in_ready, e);
      end
    end
    drive(1'b1, I_ADD, 1'b1, 1'b0);
    tests_run++;
    if (bus.in_ready !== 1'b1 || obs() !== e) begin
      tests_failed++;
      $display("FAIL lsl_release: got rdy=%b word=%h want 1/%h", bus.in_ready, obs(), e);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (bus.out_valid !== 1'b1 || obs() !== add_word()) begin
      tests_failed++;
      $display("FAIL no_bubble: got valid=%b word=%h want 1/%h", bus.out_valid, obs(), add_word());
    end
    drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_jpl();
    word_t u1, u2;
    u1 = '0; u2 = '0;
    u1.rw = 1'b1; u1.da = 3'd2; u1.aa = 3'd3; u1.fs = 4'b1100;
    u2.bs = 2'b01; u2.fs = 4'b1000; u2.mb = 1'b1; u2.cs = 1'b1; u2.aa = 3'd3; u2.uop_last = 1'b1;
    drive(1'b1, I_JPL, 1'b1, 1'b0);
    drive(1'b1, I_ADD, 1'b1, 1'b0);
    tests_run++;
    if (bus.out_valid !== 1'b1 || obs() !== u1 || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL jpl_uop1: got valid=%b word=%h rdy=%b want 1/%h/0",
               bus.out_valid, obs(), bus.in_ready, u1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (bus.out_valid !== 1'b1 || obs() !== u2 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL jpl_uop2: got valid=%b word=%h rdy=%b want 1/%h/1",
               bus.out_valid, obs(), bus.in_ready, u2);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL jpl_drain: got valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, I_JPL, 1'b0, 1'b0);
    drive(1'b1, I_ADD, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_jpl2: got valid=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    drive(1'b1, I_ADD, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL flush_drops_accept: got valid=%b want 0", bus.out_valid);
    end
    drive(1'b1, I_ADD, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (bus.out_valid !== 1'b1 || obs() !== add_word()) begin
      tests_failed++;
      $display("FAIL flush_resume: got valid=%b word=%h want 1/%h", bus.out_valid, obs(), add_word());
    end
    drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_illegal();
    drive(1'b1, I_ILL, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (bus.out_valid !== 1'b1 || obs() !== nop_word()) begin
      tests_failed++;
      $display("FAIL illegal_nop: got valid=%b word=%h want 1/%h", bus.out_valid, obs(), nop_word());
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
    tests_run++;
    if (bus.illegal !== 1'b1 || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL illegal_trap: got illegal=%b rdy=%b want 1/0", bus.illegal, bus.in_ready);
    end
    drive(1'b1, I_ADD, 1'b1, 1'b0);
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.illegal !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_sticky: got valid=%b rdy=%b illegal=%b want 0/0/1",
               bus.out_valid, bus.in_ready, bus.illegal);
    end
    drive(1'b0, '0, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (bus.illegal !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_flush: got illegal=%b rdy=%b want 0/1", bus.illegal, bus.in_ready);
    end
`else
    tests_run++;
    if (bus.illegal !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_notrap: got illegal=%b rdy=%b want 0/1", bus.illegal, bus.in_ready);
    end
    drive(1'b1, I_ADD, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (bus.out_valid !== 1'b1 || obs() !== add_word()) begin
      tests_failed++;
      $display("FAIL illegal_next: got valid=%b word=%h want 1/%h", bus.out_valid, obs(), add_word());
    end
`endif
    drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, I_JPL, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b1; bus.instruction = I_ADD; bus.out_ready = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_in_ready: got %b want 0", bus.in_ready);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || obs() !== '0 || bus.illegal !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got valid=%b word=%h illegal=%b want 0/0/0",
               bus.out_valid, obs(), bus.illegal);
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_uop2_dropped: got valid=%b want 0", bus.out_valid);
    end
    drive(1'b1, I_ADD, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (bus.out_valid !== 1'b1 || obs() !== add_word()) begin
      tests_failed++;
      $display("FAIL midrst_resume: got valid=%b word=%h want 1/%h", bus.out_valid, obs(), add_word());
    end
    drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic        v, ordy, exp_valid, exp_rdy;
    logic [4:0]  op;
    logic [16:0] ins;
    int          pick, npick;
    exp_q.delete();
`ifdef DECODE_ILLEGAL_TRAP_EN
    npick = 3;
`else
    npick = 4;
`endif
    for (int cyc = 0; cyc < 610; cyc++) begin
      pick = $urandom_range(0, npick);
      case (pick)
        0:       op = 5'd0;
        1:       op = 5'd2;
        2:       op = 5'd5;
        3:       op = 5'd16;
        default: op = 5'(21 + $urandom_range(0, 10));
      endcase
      ins  = {op, 12'($urandom)};
      v    = (cyc < 600) && ($urandom_range(0, 99) < 70);
      ordy = (cyc >= 600) || ($urandom_range(0, 99) < 65);
      drive(v, ins, ordy, 1'b0);
      exp_valid = exp_q.size() > 0;
      exp_rdy   = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
      tests_run++;
      if (bus.out_valid !== exp_valid) begin
        tests_failed++;
        $display("FAIL rand_valid@%0d: got %b want %b", cyc, bus.out_valid, exp_valid);
      end
      if (exp_valid) begin
        tests_run++;
        if (obs() !== exp_q[0]) begin
          tests_failed++;
          $display("FAIL rand_word@%0d: got %h want %h", cyc, obs(), exp_q[0]);
        end
      end
      tests_run++;
      if (bus.in_ready !== exp_rdy) begin
        tests_failed++;
        $display("FAIL rand_in_ready@%0d: got %b want %b", cyc, bus.in_ready, exp_rdy);
      end
      if (exp_valid && ordy) void'(exp_q.pop_front());
      if (v && exp_rdy) push_model(ins);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.instruction = '0;
    bus.out_ready   = 1'b0;
    bus.flush       = 1'b0;
    test_reset();
    test_add();
    test_lsl_backpressure();
    test_jpl();
    test_flush();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, flow-controlled instruction decode stage for the Batkiri datapath, sitting between instruction fetch and the register file / function unit. Replaces the purely combinational decode path with a one-entry output register under a valid/ready handshake, parametrised field widths, a two-micro-op expansion for JPL (link, then jump), flush support, and optional illegal-opcode trapping.

## Interface
- `IW`, 17, instruction width
- `OPW`, 5, opcode width, at `instruction[IW-1 -: OPW]`
- `RAW`, 3, register address width; DA, AA and BA fields are packed directly below the opcode, in that order
- `SHW`, 3, shift amount width, at `instruction[SHW-1:0]`

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset. Synchronous, active-low.
- `in_valid` in 1 / `in_ready` out 1: instruction handshake
- `instruction` in IW: instruction word
- `flush` in 1: discard the held and in-flight decode
- `out_valid` out 1 / `out_ready` in 1: control-word handshake
- `rw`, `ps`, `mw`, `ma`, `mb`, `cs`, `oe` out 1 each: register write, zero toggle, memory write, mux A, mux B, constant select, output write enable
- `md`, `bs` out 2 each; `fs` out 4; `da`, `aa`, `ba` out RAW; `sh` out SHW
- `uop_last` out 1: high on the final micro-op of an instruction
- `illegal` out 1: sticky illegal-opcode flag

## Operation
- FSM states:
  - `RUN`: normal decode.
  - `JPL2`: second micro-op of JPL is pending.
  - `TRAP`: illegal opcode held. Present only with the macro.
- Accept condition: `in_valid && in_ready`.
- `in_ready = rst_n && state==RUN && (!out_valid || out_ready)`.
- On accept, the opcode decodes through the package control table (opcodes 0–20, NOP..INP). All control fields are assigned for every opcode. Unused fields are 0.
- Output register update:
  - Loads on accept, or on leaving `JPL2`.
  - Holds while `out_valid && !out_ready`.
  - Clears `out_valid` when the current word is taken and nothing new is loaded.
- JPL (opcode 2) expands into two micro-ops:
  - Micro-op 1: rw=1, da=DA field, aa=AA field, fs=1100, all others 0, uop_last=0. FSM moves to `JPL2`.
  - Micro-op 2 loads when micro-op 1 is taken: rw=0, bs=01, fs=1000, mb=1, cs=1, aa=AA field, uop_last=1. FSM returns to `RUN`.
- Every other opcode is a single micro-op with uop_last=1.
- `flush` has priority over everything except reset. On the next edge: out_valid=0, state=`RUN`, `illegal`=0. An accept in the same cycle is discarded.
- Opcodes 21..2^OPW-1 are illegal; handling is set by `DECODE_ILLEGAL_TRAP_EN` (see Configuration).

## Timing
- Latency: one cycle. An instruction accepted at edge N is visible with out_valid=1 after edge N.
- Throughput: 1 instruction/cycle with out_ready held high. JPL costs 2 cycles, and in_ready=0 during `JPL2`.
- Reset: out_valid=0, all control outputs 0, uop_last=0, illegal=0, state `RUN`. in_ready=0 while rst_n=0.
- Reset mid-JPL: micro-op 2 is dropped.
- Back-pressure: outputs stay stable while `out_valid && !out_ready`.
- Simultaneous take and accept: the new word loads in the same edge with no bubble.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode loads NOP controls with uop_last=1 and sets `illegal`=1.
  - FSM enters `TRAP`, forcing in_ready=0 until `flush`.
- Undefined:
  - An illegal opcode decodes as NOP and the stage keeps accepting.
  - `illegal` is tied 0 and `TRAP` does not exist.

## Structure
- Shared package `batkiri_pkg` holds:
  - opcode localparams NOP..INP (0–20)
  - a `ctrl_t` packed struct for all control fields
  - `CTRL_TABLE` constant mapping opcode to `ctrl_t` field sources
  - FS/BS/MD encodings
- Sub-module `decode_lut`: purely combinational opcode+fields to `ctrl_t`, reused by the JPL micro-op selection.
- `decode_stage` owns the FSM, the output register and the handshake.

## Test plan
- ADD: instruction 0x10688 with out_ready=1 → one cycle later out_valid=1, rw=1, da=3, aa=2, ba=1, fs=0001, uop_last=1.
- LSL: 0x5645 → rw=1, da=3, aa=1, fs=0110, sh=5; back-pressure (out_ready=0 for 3 cycles) holds outputs stable with in_ready=0.
- JPL: 0x24C0 → micro-op 1 (rw=1, da=2, aa=3, fs=1100, uop_last=0), then micro-op 2 (bs=01, fs=1000, mb=1, cs=1, aa=3, uop_last=1); in_ready=0 in between.
- Flush: assert during `JPL2` → next cycle out_valid=0, state `RUN`, in_ready=1; the concurrent input is dropped.
- Illegal: 0x1F000 with macro → illegal=1, NOP controls, in_ready=0 until flush; without macro → NOP, illegal=0, next instruction accepted.
- Reset: rst_n=0 mid-stream → all outputs 0 on the next edge; stream resumes cleanly after release.
